// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file write-port
// controller.
//   REG_DATA_W : register width
//   REG_ADDR_W : register address width
//   NUM_REGS   : number of architectural registers
//   state_e    : write-port controller state (CLEAR, RUN)
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per register marking an outstanding load.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   set_en_i, set_addr_i     : mark a register busy (load issued)
//   clr_en_i, clr_addr_i     : mark a register free (load written back)
//   addr_a_i, addr_b_i       : query addresses
//   busy_a_o, busy_b_o       : combinational busy bit of each query address
// Set wins over clear when both target the same bit in one cycle.
module regfile_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  output logic              busy_a_o,
  output logic              busy_b_o
);

  localparam int NUM = 1 << ADDR_W;

  logic [NUM-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    // Clear first so a same-cycle set on the same bit overrides it.
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_a_o = busy_q[addr_a_i];
  assign busy_b_o = busy_q[addr_b_i];

endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: write-port controller for the register file RAM.
// After reset it zero-clears every register (CLEAR), then arbitrates the
// single RAM write port (RUN) between pipeline writeback and load returns:
//   writeback > buffered load > direct load.
// A load that collides with a writeback is held in a 1-entry buffer.
// Register 0 is never written; requests to it handshake and are dropped.
// Optional build macro: REGFILE_SCOREBOARD_EN adds the pending-load
// scoreboard; without it sb_busy_a/b are tied low and ld_issue is ignored.
// Ports:
//   clock, resetn                    : clock, asynchronous active-low reset
//   wb_valid/wb_addr/wb_data/wb_ready: writeback request channel
//   ld_issue/ld_issue_addr           : load issue (scoreboard set)
//   ld_valid/ld_addr/ld_data/ld_ready: load return channel
//   sb_addr_a/b, sb_busy_a/b         : scoreboard hazard queries
//   ram_wren/ram_wraddress/ram_data  : RAM write port (combinational)
//   init_done                        : clear sequence finished
import regfile_pkg::*;

module regfile_wr_ctrl #(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_issue_addr,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] sb_addr_a,
  input  logic [ADDR_W-1:0] sb_addr_b,
  output logic              sb_busy_a,
  output logic              sb_busy_b,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [DATA_W-1:0] ram_data,
  output logic              init_done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              buf_vld_q, buf_vld_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  logic              wren_c;
  logic              wb_fire, ld_fire;
  // A load write reaching the RAM this cycle (clears its scoreboard bit).
  logic              ld_wr_en;
  logic [ADDR_W-1:0] ld_wr_addr;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    buf_vld_d     = buf_vld_q;
    buf_addr_d    = buf_addr_q;
    buf_data_d    = buf_data_q;
    wren_c        = 1'b0;
    ram_wraddress = '0;
    ram_data      = '0;
    wb_ready      = 1'b0;
    ld_ready      = 1'b0;
    init_done     = 1'b0;
    wb_fire       = 1'b0;
    ld_fire       = 1'b0;
    ld_wr_en      = 1'b0;
    ld_wr_addr    = '0;

    case (state_q)
      CLEAR: begin
        wren_c        = 1'b1;
        ram_wraddress = cnt_q;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end

      RUN: begin
        wb_ready  = 1'b1;
        init_done = 1'b1;
        ld_ready  = !buf_vld_q;
        wb_fire   = wb_valid;
        ld_fire   = ld_valid && !buf_vld_q;

        if (wb_fire) begin
          ram_wraddress = wb_addr;
          ram_data      = wb_data;
          wren_c        = (wb_addr != '0);
          // Port is taken: park the load, unless it targets r0 (dropped).
          if (ld_fire && ld_addr != '0) begin
            buf_vld_d  = 1'b1;
            buf_addr_d = ld_addr;
            buf_data_d = ld_data;
          end
        end else if (buf_vld_q) begin
          // ld_ready was low, so no new load can arrive while draining.
          ram_wraddress = buf_addr_q;
          ram_data      = buf_data_q;
          wren_c        = 1'b1;
          buf_vld_d     = 1'b0;
          ld_wr_en      = 1'b1;
          ld_wr_addr    = buf_addr_q;
        end else if (ld_fire && ld_addr != '0) begin
          ram_wraddress = ld_addr;
          ram_data      = ld_data;
          wren_c        = 1'b1;
          ld_wr_en      = 1'b1;
          ld_wr_addr    = ld_addr;
        end
      end

      default: state_d = CLEAR;
    endcase
  end

  // The RAM has no reset of its own, so keep its write strobe off while
  // reset is held even though the state already sits in CLEAR.
  assign ram_wren = wren_c & resetn;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      buf_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_vld_q  <= buf_vld_d;
    end
  end

  // Buffer payload is only meaningful while buf_vld_q is set.
  always_ff @(posedge clock) begin
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic sb_set_en;

  // Loads issued during CLEAR are ignored; r0 is never tracked.
  assign sb_set_en = ld_issue && (state_q == RUN) && (ld_issue_addr != '0);

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk_i      (clock),
    .rst_ni     (resetn),
    .set_en_i   (sb_set_en),
    .set_addr_i (ld_issue_addr),
    .clr_en_i   (ld_wr_en),
    .clr_addr_i (ld_wr_addr),
    .addr_a_i   (sb_addr_a),
    .addr_b_i   (sb_addr_b),
    .busy_a_o   (sb_busy_a),
    .busy_b_o   (sb_busy_b)
  );
`else
  logic unused_sb;

  assign sb_busy_a = 1'b0;
  assign sb_busy_b = 1'b0;
  assign unused_sb = ^{ld_issue, ld_issue_addr, sb_addr_a, sb_addr_b,
                       ld_wr_en, ld_wr_addr};
`endif

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
module tb_regfile_wr_ctrl;

  logic        clock;
  logic        resetn;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        ld_issue;
  logic [4:0]  ld_issue_addr;
  logic        ld_valid;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  sb_addr_a;
  logic [4:0]  sb_addr_b;
  logic        sb_busy_a;
  logic        sb_busy_b;
  logic        ram_wren;
  logic [4:0]  ram_wraddress;
  logic [31:0] ram_data;
  logic        init_done;

  int nvec = 0;
  int nerr = 0;

  regfile_wr_ctrl dut (
    .clock         (clock),
    .resetn        (resetn),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .wb_ready      (wb_ready),
    .ld_issue      (ld_issue),
    .ld_issue_addr (ld_issue_addr),
    .ld_valid      (ld_valid),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .ld_ready      (ld_ready),
    .sb_addr_a     (sb_addr_a),
    .sb_addr_b     (sb_addr_b),
    .sb_busy_a     (sb_busy_a),
    .sb_busy_b     (sb_busy_b),
    .ram_wren      (ram_wren),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .init_done     (init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    ld_issue = 1'b0; ld_issue_addr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  initial begin
    resetn = 1'b0;
    sb_addr_a = 5'd9;
    sb_addr_b = 5'd0;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;

    // Reset values
    chk("rst_wren", ram_wren, 0);
    chk("rst_waddr", ram_wraddress, 0);
    chk("rst_wdata", ram_data, 0);
    chk("rst_wb_ready", wb_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy_a", sb_busy_a, 0);
    chk("rst_busy_b", sb_busy_b, 0);

    // Clear sequence; ld_issue held high must be ignored
    tick();
    resetn = 1'b1;
    ld_issue = 1'b1; ld_issue_addr = 5'd9;
    #1;
    for (int i = 0; i < 32; i++) begin
      chk("clr_wren", ram_wren, 1);
      chk("clr_addr", ram_wraddress, i);
      chk("clr_data", ram_data, 0);
      chk("clr_wb_ready", wb_ready, 0);
      chk("clr_ld_ready", ld_ready, 0);
      chk("clr_init_done", init_done, 0);
      tick();
    end
    idle_inputs();
    #1;
    chk("run_init_done", init_done, 1);
    chk("run_wb_ready", wb_ready, 1);
    chk("run_ld_ready", ld_ready, 1);
    chk("run_idle_wren", ram_wren, 0);
    chk("clr_issue_ignored", sb_busy_a, 0);

    // Writeback alone
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    chk("wb_wren", ram_wren, 1);
    chk("wb_addr", ram_wraddress, 5);
    chk("wb_data", ram_data, 32'hDEADBEEF);
    tick();

    // Writeback + load collide: load buffered, drained next free cycle
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h11;
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h22;
    #1;
    chk("col_ld_ready", ld_ready, 1);
    chk("col_wren", ram_wren, 1);
    chk("col_addr", ram_wraddress, 3);
    chk("col_data", ram_data, 32'h11);
    tick();
    idle_inputs();
    #1;
    chk("drain_ld_ready", ld_ready, 0);
    chk("drain_wren", ram_wren, 1);
    chk("drain_addr", ram_wraddress, 7);
    chk("drain_data", ram_data, 32'h22);
    tick();
    #1;
    chk("drained_ld_ready", ld_ready, 1);
    chk("drained_wren", ram_wren, 0);

    // Buffer waits behind a second writeback
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    ld_valid = 1'b1; ld_addr = 5'd8; ld_data = 32'h88;
    tick();
    ld_valid = 1'b0;
    wb_addr = 5'd6; wb_data = 32'h66;
    #1;
    chk("wait_addr", ram_wraddress, 6);
    chk("wait_data", ram_data, 32'h66);
    chk("wait_ld_ready", ld_ready, 0);
    tick();
    idle_inputs();
    #1;
    chk("wait_drain_addr", ram_wraddress, 8);
    chk("wait_drain_data", ram_data, 32'h88);
    chk("wait_drain_wren", ram_wren, 1);
    tick();

    // Direct load
    ld_valid = 1'b1; ld_addr = 5'd10; ld_data = 32'hAA;
    #1;
    chk("dir_wren", ram_wren, 1);
    chk("dir_addr", ram_wraddress, 10);
    chk("dir_data", ram_data, 32'hAA);
    tick();
    idle_inputs();

    // r0: handshake without RAM write
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    #1;
    chk("r0_wb_wren", ram_wren, 0);
    chk("r0_wb_ready", wb_ready, 1);
    tick();
    idle_inputs();
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h5;
    #1;
    chk("r0_ld_wren", ram_wren, 0);
    chk("r0_ld_ready", ld_ready, 1);
    tick();
    wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h2;
    #1;
    tick();
    idle_inputs();
    #1;
    chk("r0_not_buffered", ld_ready, 1);
    chk("r0_no_drain", ram_wren, 0);

    // Scoreboard
    sb_addr_a = 5'd9; sb_addr_b = 5'd0;
    ld_issue = 1'b1; ld_issue_addr = 5'd9;
    #1;
    chk("sb_not_yet", sb_busy_a, 0);
    tick();
    idle_inputs();
    #1;
`ifdef REGFILE_SCOREBOARD_EN
    chk("sb_set", sb_busy_a, 1);
    ld_issue = 1'b1; ld_issue_addr = 5'd0;
    tick();
    idle_inputs();
    #1;
    chk("sb_r0", sb_busy_b, 0);
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h1;
    tick();
    idle_inputs();
    #1;
    chk("sb_wb_keeps", sb_busy_a, 1);
    ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h99;
    #1;
    chk("sb_ret_addr", ram_wraddress, 9);
    tick();
    idle_inputs();
    #1;
    chk("sb_cleared", sb_busy_a, 0);
    ld_issue = 1'b1; ld_issue_addr = 5'd9;
    tick();
    ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 32'h98;
    tick();
    idle_inputs();
    #1;
    chk("sb_set_wins", sb_busy_a, 1);
`else
    chk("sb_tied_a", sb_busy_a, 0);
    chk("sb_tied_b", sb_busy_b, 0);
`endif

    // Reset mid-RUN with buffer full
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h77;
    tick();
    idle_inputs();
    #1;
    chk("pre_rst_buf_full", ld_ready, 0);
    resetn = 1'b0;
    #1;
    chk("rr_wren", ram_wren, 0);
    chk("rr_init_done", init_done, 0);
    chk("rr_busy_a", sb_busy_a, 0);
    tick();
    resetn = 1'b1;
    #1;
    chk("rr_clr_addr0", ram_wraddress, 0);
    chk("rr_clr_wren", ram_wren, 1);

    // Reset mid-clear at count 12
    repeat (12) tick();
    #1;
    chk("mc_addr12", ram_wraddress, 12);
    resetn = 1'b0;
    #1;
    chk("mc_rst_wren", ram_wren, 0);
    chk("mc_rst_addr", ram_wraddress, 0);
    tick();
    resetn = 1'b1;
    #1;
    chk("mc_restart_addr", ram_wraddress, 0);
    chk("mc_restart_wren", ram_wren, 1);
    repeat (31) tick();
    #1;
    chk("mc_last_addr", ram_wraddress, 31);
    chk("mc_last_done", init_done, 0);
    tick();
    #1;
    chk("mc_run_done", init_done, 1);
    chk("mc_buf_gone", ld_ready, 1);
    chk("mc_no_drain", ram_wren, 0);
    chk("mc_sb_empty", sb_busy_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_wr_ctrl.md
# regfile_wr_ctrl

Write-port controller for the 32×32 register file RAM (one asynchronous read port, one synchronous write port).
- Arbitrates the single write port between pipeline writeback and out-of-order load returns.
- Sequences a zero-clear of all registers after reset, since the RAM itself has no reset.
- Keeps a pending-load scoreboard that the decode stage queries for hazards.
- Sits between the execute/memory stages and the register file RAM.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register address width (2**ADDR_W registers)

- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- wb_valid  in  1  pipeline writeback request
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- wb_ready  out  1  writeback accepted; low only while clearing
- ld_issue  in  1  load issued to memory (scoreboard set)
- ld_issue_addr  in  ADDR_W  load destination at issue
- ld_valid  in  1  load return request
- ld_addr  in  ADDR_W  load return destination
- ld_data  in  DATA_W  load return value
- ld_ready  out  1  load return accepted
- sb_addr_a, sb_addr_b  in  ADDR_W  scoreboard query addresses
- sb_busy_a, sb_busy_b  out  1  query address has a load pending
- ram_wren  out  1  to RAM wren
- ram_wraddress  out  ADDR_W  to RAM wraddress
- ram_data  out  DATA_W  to RAM data
- init_done  out  1  clear sequence complete

## Operation
- States: CLEAR, RUN. Reset enters CLEAR with clear counter 0; 1-entry load buffer empty; scoreboard all 0.
- CLEAR:
  - Each cycle: ram_wren=1, ram_wraddress=counter, ram_data=0; counter increments.
  - When counter=2**ADDR_W−1, move to RUN.
  - wb_ready=0 and ld_ready=0 throughout. ld_issue is ignored.
- RUN, write-port priority per cycle: wb fire > buffered load > direct ld fire.
  - wb fire = wb_valid & wb_ready. wb_ready=1 always in RUN.
  - ld_ready = buffer empty.
  - ld fire with a wb fire in the same cycle: the load is captured into the buffer.
  - ld fire with no wb fire and buffer empty: the load writes the RAM directly that cycle.
  - Buffer drains in the first cycle with no wb fire.
- r0: accepted requests (wb or load) addressed to register 0 complete their handshake but never assert ram_wren. A load to r0 is dropped without being buffered.
- Scoreboard:
  - ld_issue sets bit ld_issue_addr; never for r0.
  - A load write reaching the RAM clears its bit.
  - Set and clear of the same bit in one cycle: set wins.
  - A wb write to a busy address does not clear the bit.
- Queries are combinational on current scoreboard state.

## Timing
- Reset values: ram_wren=0 while resetn low; wb_ready=0, ld_ready=0, init_done=0, sb_busy_*=0, ram_wraddress=0, ram_data=0.
- Clear takes exactly 2**ADDR_W (32) cycles after reset release. init_done=1 from the cycle RUN is entered, and wb_ready=1 in that same cycle.
- ram_* are combinational from the accepted request or buffer. The RAM commits on the same edge that accepts the request (zero added latency).
- A buffered load commits 1 cycle after capture if no wb fire occurs that cycle; otherwise it waits.
- Scoreboard bits update on the edge; sb_busy reflects them the following cycle.
- resetn asserted mid-clear or mid-RUN: immediate return to CLEAR with counter 0. Buffer and scoreboard are discarded.

## Configuration
- REGFILE_SCOREBOARD_EN defined: scoreboard is present as described.
- Not defined: no scoreboard state; sb_busy_a/b tied 0; ld_issue and ld_issue_addr ignored. Arbitration and clear are unchanged.

## Structure
- Package regfile_pkg: REG_DATA_W=32, REG_ADDR_W=5, NUM_REGS=32, state enum (CLEAR, RUN).
- Sub-module regfile_scoreboard: set/clear/query bit vector, instantiated only under REGFILE_SCOREBOARD_EN.
- Arbiter, buffer and clear FSM live in the top module.

## Test plan
- Release reset → 32 consecutive cycles with ram_wren=1, addresses 0..31, data 0; then init_done=1 and wb_ready=1.
- RUN, wb_valid only, addr 5, data 0xDEADBEEF → same-cycle ram_wren=1, addr 5, data 0xDEADBEEF.
- Same cycle wb (addr 3, 0x11) and ld (addr 7, 0x22) → cycle N writes r3=0x11 and captures the load, ld_ready=0 at N+1; cycle N+1 with no wb writes r7=0x22.
- ld_issue addr 9 → sb_busy_a=1 for sb_addr_a=9; load return to 9 written → sb_busy_a=0 next cycle. ld_issue 9 in the same cycle as the return → stays 1.
- wb addr 0 data 0xFFFFFFFF, and ld_issue addr 0 → ram_wren=0, handshake completes, scoreboard bit 0 stays 0.
- resetn pulsed low at clear count 12 and while the buffer is full → buffer and scoreboard empty; clear restarts at address 0.
